// File: rtl/hwag_coil_channel_if.sv
// rtl/hwag_coil_channel_if.sv - angle, configuration and coil signals of one coil channel
// The channel drives the slave side; the angle source and register block drive the master side.
interface hwag_coil_channel_if #(
  parameter int ANGLE_W = 16,
  parameter int DWELL_W = 24
);
  logic               hwag_start;
  logic               angle_tick;
  logic [ANGLE_W-1:0] angle;
  logic               cfg_wr;
  logic [ANGLE_W-1:0] cfg_on;
  logic [ANGLE_W-1:0] cfg_off;
  logic [DWELL_W-1:0] cfg_dwell_max;
  logic               coil;
  logic               cfg_err;
  logic               dwell_fault;

  modport master (
    output hwag_start, angle_tick, angle,
    output cfg_wr, cfg_on, cfg_off, cfg_dwell_max,
    input  coil, cfg_err, dwell_fault
  );

  modport slave (
    input  hwag_start, angle_tick, angle,
    input  cfg_wr, cfg_on, cfg_off, cfg_dwell_max,
    output coil, cfg_err, dwell_fault
  );
endinterface

// File: rtl/hwag_coil_channel.sv
// rtl/hwag_coil_channel.sv - angle-driven ignition coil channel with double-buffered config
// Charges the coil between on/off angle crossings; a dwell watchdog bounds the charge time.
module hwag_coil_channel #(
  parameter int ANGLE_W   = 16,
  parameter int ANGLE_MOD = 3840,
  parameter int DWELL_W   = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  hwag_coil_channel_if.slave   bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SYNC    = 2'd1;
  localparam logic [1:0] ST_WAIT_ON = 2'd2;
  localparam logic [1:0] ST_CHARGE  = 2'd3;

  localparam logic [ANGLE_W:0] MOD_V  = (ANGLE_W+1)'(ANGLE_MOD);
  localparam logic [ANGLE_W:0] HALF_V = MOD_V >> 1;

  // (a - b) mod ANGLE_MOD for in-range angles; one extra bit keeps a + MOD from overflowing.
  function automatic logic [ANGLE_W:0] mod_sub(input logic [ANGLE_W-1:0] a,
                                               input logic [ANGLE_W-1:0] b);
    logic [ANGLE_W:0] ae;
    logic [ANGLE_W:0] be;
    ae = {1'b0, a};
    be = {1'b0, b};
    if (ae >= be) mod_sub = ae - be;
    else          mod_sub = ae + MOD_V - be;
  endfunction

  logic [1:0]         state_q,          state_d;
  logic               coil_q,           coil_d;
  logic               cfg_err_q,        cfg_err_d;
  logic               dwell_fault_q,    dwell_fault_d;
  logic [ANGLE_W-1:0] prev_q,           prev_d;
  logic               prev_valid_q,     prev_valid_d;
  logic [DWELL_W-1:0] dwell_q,          dwell_d;
  logic [ANGLE_W-1:0] shadow_on_q,      shadow_on_d;
  logic [ANGLE_W-1:0] shadow_off_q,     shadow_off_d;
  logic [DWELL_W-1:0] shadow_dwell_q,   shadow_dwell_d;
  logic               shadow_pending_q, shadow_pending_d;
  logic [ANGLE_W-1:0] active_on_q,      active_on_d;
  logic [ANGLE_W-1:0] active_off_q,     active_off_d;
  logic [DWELL_W-1:0] active_dwell_q,   active_dwell_d;

  logic [ANGLE_W:0] step_dist;
  logic [ANGLE_W:0] on_dist;
  logic [ANGLE_W:0] off_dist;
  logic             step_ok;
  logic             on_x;
  logic             off_x;
  logic             wd_hit;
  logic             cfg_ok;
  logic             xfer;

  // A target is crossed when it lies in (prev, angle] going forward by less than half a turn.
  always_comb begin
    step_dist = mod_sub(bus.angle, prev_q);
    on_dist   = mod_sub(active_on_q, prev_q);
    off_dist  = mod_sub(active_off_q, prev_q);
    step_ok   = bus.angle_tick && prev_valid_q &&
                (step_dist != '0) && (step_dist < HALF_V);
    on_x      = step_ok && (on_dist  != '0) && (on_dist  <= step_dist);
    off_x     = step_ok && (off_dist != '0) && (off_dist <= step_dist);
    wd_hit    = (active_dwell_q != '0) &&
                (dwell_q == active_dwell_q - DWELL_W'(1));
    cfg_ok    = ({1'b0, bus.cfg_on}  < MOD_V) &&
                ({1'b0, bus.cfg_off} < MOD_V) &&
                (bus.cfg_on != bus.cfg_off);
  end

  always_comb begin
    state_d          = state_q;
    coil_d           = coil_q;
    cfg_err_d        = 1'b0;
    dwell_fault_d    = 1'b0;
    prev_d           = prev_q;
    prev_valid_d     = prev_valid_q;
    dwell_d          = dwell_q;
    shadow_on_d      = shadow_on_q;
    shadow_off_d     = shadow_off_q;
    shadow_dwell_d   = shadow_dwell_q;
    shadow_pending_d = shadow_pending_q;
    active_on_d      = active_on_q;
    active_off_d     = active_off_q;
    active_dwell_d   = active_dwell_q;
    xfer             = 1'b0;

    if (!bus.hwag_start) begin
      state_d      = ST_IDLE;
      coil_d       = 1'b0;
      prev_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_SYNC;
        ST_SYNC: begin
          if (bus.angle_tick) begin
            prev_d       = bus.angle;
            prev_valid_d = 1'b1;
            xfer         = 1'b1;
            state_d      = ST_WAIT_ON;
          end
        end
        ST_WAIT_ON: begin
          if (bus.angle_tick) prev_d = bus.angle;
          // On and off in one tick is a zero-length cycle: coil stays off.
          if (on_x && off_x) begin
            xfer = 1'b1;
          end else if (on_x) begin
            state_d = ST_CHARGE;
            coil_d  = 1'b1;
            dwell_d = '0;
          end
        end
        ST_CHARGE: begin
          dwell_d = dwell_q + DWELL_W'(1);
          if (bus.angle_tick) prev_d = bus.angle;
          if (off_x) begin
            state_d = ST_WAIT_ON;
            coil_d  = 1'b0;
            xfer    = 1'b1;
          end else if (wd_hit) begin
            state_d       = ST_WAIT_ON;
            coil_d        = 1'b0;
            dwell_fault_d = 1'b1;
            xfer          = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Transfer reads the pre-write shadow, so a same-cycle write stays pending.
    if (xfer && shadow_pending_q) begin
      active_on_d      = shadow_on_q;
      active_off_d     = shadow_off_q;
      active_dwell_d   = shadow_dwell_q;
      shadow_pending_d = 1'b0;
    end

    if (bus.cfg_wr) begin
      if (cfg_ok) begin
        shadow_on_d      = bus.cfg_on;
        shadow_off_d     = bus.cfg_off;
        shadow_dwell_d   = bus.cfg_dwell_max;
        shadow_pending_d = 1'b1;
      end else begin
        cfg_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      coil_q           <= 1'b0;
      cfg_err_q        <= 1'b0;
      dwell_fault_q    <= 1'b0;
      prev_q           <= '0;
      prev_valid_q     <= 1'b0;
      dwell_q          <= '0;
      shadow_on_q      <= '0;
      shadow_off_q     <= '0;
      shadow_dwell_q   <= '0;
      shadow_pending_q <= 1'b0;
      active_on_q      <= '0;
      active_off_q     <= '0;
      active_dwell_q   <= '0;
    end else begin
      state_q          <= state_d;
      coil_q           <= coil_d;
      cfg_err_q        <= cfg_err_d;
      dwell_fault_q    <= dwell_fault_d;
      prev_q           <= prev_d;
      prev_valid_q     <= prev_valid_d;
      dwell_q          <= dwell_d;
      shadow_on_q      <= shadow_on_d;
      shadow_off_q     <= shadow_off_d;
      shadow_dwell_q   <= shadow_dwell_d;
      shadow_pending_q <= shadow_pending_d;
      active_on_q      <= active_on_d;
      active_off_q     <= active_off_d;
      active_dwell_q   <= active_dwell_d;
    end
  end

  assign bus.coil        = coil_q;
  assign bus.cfg_err     = cfg_err_q;
  assign bus.dwell_fault = dwell_fault_q;

endmodule

// File: tb/tb_hwag_coil_channel.sv
// tb/tb_hwag_coil_channel.sv - directed and random checks of hwag_coil_channel against a reference model
module tb_hwag_coil_channel;
  localparam int AW = 16;
  localparam int DW = 24;
  localparam int M  = 3840;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hwag_coil_channel_if #(.ANGLE_W(AW), .DWELL_W(DW)) bus ();

  hwag_coil_channel #(.ANGLE_W(AW), .ANGLE_MOD(M), .DWELL_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: phase 0 unsynced, 1 awaiting first tick, 2 armed, 3 charging.
  int m_phase, m_prev, m_charged;
  bit m_prev_ok, m_coil, m_err, m_fault;
  int sh_on, sh_off, sh_dw, ac_on, ac_off, ac_dw;
  bit sh_pend;

  function automatic int md(input int x);
    return ((x % M) + M) % M;
  endfunction

  function automatic bit crosses(input int prev, input int cur, input int t);
    int d;
    int dt;
    d  = md(cur - prev);
    dt = md(t - prev);
    return (d != 0) && (d < M / 2) && (dt >= 1) && (dt <= d);
  endfunction

  task automatic model_step();
    bit on_x, off_x, xfer, wr_ok;
    int a;
    if (rst) begin
      m_phase = 0; m_prev_ok = 0; m_coil = 0; m_err = 0; m_fault = 0;
      sh_on = 0; sh_off = 0; sh_dw = 0; sh_pend = 0;
      ac_on = 0; ac_off = 0; ac_dw = 0; m_charged = 0; m_prev = 0;
    end else begin
      m_err = 0; m_fault = 0; xfer = 0; on_x = 0; off_x = 0;
      a = int'(bus.angle);
      wr_ok = bus.cfg_wr && (int'(bus.cfg_on) < M) && (int'(bus.cfg_off) < M) &&
              (bus.cfg_on != bus.cfg_off);
      if (bus.cfg_wr && !wr_ok) m_err = 1;
      if (!bus.hwag_start) begin
        m_phase = 0; m_coil = 0; m_prev_ok = 0;
      end else begin
        case (m_phase)
          0: m_phase = 1;
          1: if (bus.angle_tick) begin
               m_prev = a; m_prev_ok = 1; xfer = 1; m_phase = 2;
             end
          2: if (bus.angle_tick) begin
               on_x  = m_prev_ok && crosses(m_prev, a, ac_on);
               off_x = m_prev_ok && crosses(m_prev, a, ac_off);
               m_prev = a;
               if (on_x && off_x) xfer = 1;
               else if (on_x) begin m_phase = 3; m_coil = 1; m_charged = 0; end
             end
          default: begin
            m_charged++;
            if (bus.angle_tick) begin
              off_x  = crosses(m_prev, a, ac_off);
              m_prev = a;
            end
            if (off_x) begin
              m_phase = 2; m_coil = 0; xfer = 1;
            end else if (ac_dw != 0 && m_charged == ac_dw) begin
              m_phase = 2; m_coil = 0; xfer = 1; m_fault = 1;
            end
          end
        endcase
      end
      if (xfer && sh_pend) begin
        ac_on = sh_on; ac_off = sh_off; ac_dw = sh_dw; sh_pend = 0;
      end
      if (wr_ok) begin
        sh_on = int'(bus.cfg_on); sh_off = int'(bus.cfg_off);
        sh_dw = int'(bus.cfg_dwell_max); sh_pend = 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    chk("model_coil", bus.coil, m_coil);
    chk("model_cfg_err", bus.cfg_err, m_err);
    chk("model_dwell_fault", bus.dwell_fault, m_fault);
  endtask

  task automatic tick(input int a);
    bus.angle      = a[AW-1:0];
    bus.angle_tick = 1'b1;
    step();
    bus.angle_tick = 1'b0;
  endtask

  task automatic cfg(input int on, input int off, input int dw);
    bus.cfg_on        = on[AW-1:0];
    bus.cfg_off       = off[AW-1:0];
    bus.cfg_dwell_max = dw[DW-1:0];
    bus.cfg_wr        = 1'b1;
    step();
    bus.cfg_wr = 1'b0;
  endtask

  task automatic resync();
    bus.hwag_start = 1'b0;
    step();
    bus.hwag_start = 1'b1;
    step();
  endtask

  initial begin
    int hi, nf, a, cur, r, on, off, dw, inc;
    rst = 1'b1;
    bus.hwag_start = 1'b0; bus.angle_tick = 1'b0; bus.angle = '0;
    bus.cfg_wr = 1'b0; bus.cfg_on = '0; bus.cfg_off = '0; bus.cfg_dwell_max = '0;
    step();
    step();
    chk("reset_coil", bus.coil, 0);
    chk("reset_cfg_err", bus.cfg_err, 0);
    chk("reset_dwell_fault", bus.dwell_fault, 0);
    rst = 1'b0;

    // sync and basic cycle, then config safety mid-charge
    cfg(100, 200, 0);
    chk("cfg_valid_no_err", bus.cfg_err, 0);
    bus.hwag_start = 1'b1;
    step();
    for (int k = 0; k <= 160; k++) begin
      tick(k);
      chk("basic_cycle", bus.coil, (k >= 100 && k < 200));
    end
    cfg(700, 700, 0);
    chk("cfg_on_eq_off_err", bus.cfg_err, 1);
    step();
    chk("cfg_err_one_pulse", bus.cfg_err, 0);
    cfg(4000, 10, 0);
    chk("cfg_out_of_range_err", bus.cfg_err, 1);
    cfg(1000, 1100, 0);
    chk("cfg_in_charge_ok", bus.cfg_err, 0);
    for (int k = 170; k <= 1300; k += 10) begin
      tick(k);
      chk("reconfig_cycle", bus.coil, (k < 200) || (k >= 1000 && k < 1100));
    end

    // wrap-around through 3839 -> 0
    cfg(3800, 40, 0);
    resync();
    tick(3790);
    chk("wrap_first_tick", bus.coil, 0);
    for (int k = 1; k <= 100; k++) begin
      a = (3790 + k) % M;
      tick(a);
      chk("wrap_cycle", bus.coil, (a >= 3800 || a < 40));
    end

    // angle jumps and the half-turn boundary
    cfg(500, 3000, 0);
    resync();
    tick(480);
    tick(520);  chk("jump_480_520_on", bus.coil, 1);
    tick(1000);
    tick(2000);
    tick(3000); chk("jump_off_3000", bus.coil, 0);
    tick(480);
    tick(2500); chk("jump_480_2500_none", bus.coil, 0);
    tick(480);  chk("off_alone_ignored", bus.coil, 0);
    tick(2400); chk("jump_half_turn_none", bus.coil, 0);
    tick(499);
    tick(2418); chk("jump_just_under_half", bus.coil, 1);
    tick(2600);
    tick(3000); chk("jump_charge_end", bus.coil, 0);

    // watchdog
    cfg(100, 300, 50);
    resync();
    tick(90);
    hi = 0; nf = 0;
    for (int k = 91; k <= 150; k++) begin
      tick(k);
      hi += int'(bus.coil); nf += int'(bus.dwell_fault);
    end
    for (int k = 0; k < 100; k++) begin
      step();
      hi += int'(bus.coil); nf += int'(bus.dwell_fault);
    end
    chk("wd_coil_high_cycles", hi, 50);
    chk("wd_fault_pulses", nf, 1);
    tick(400);
    tick(3000);
    tick(50);
    tick(100);  chk("wd_rearmed_charge", bus.coil, 1);
    tick(300);  chk("wd_rearmed_off", bus.coil, 0);

    // off-crossing and watchdog expiry in the same cycle
    cfg(100, 110, 10);
    resync();
    tick(95);
    hi = 0; nf = 0;
    for (int k = 96; k <= 130; k++) begin
      tick(k);
      hi += int'(bus.coil); nf += int'(bus.dwell_fault);
    end
    chk("off_vs_wd_high_cycles", hi, 10);
    chk("off_vs_wd_no_fault", nf, 0);

    // sync loss during charge
    cfg(100, 200, 0);
    resync();
    tick(90);
    tick(110);  chk("sync_loss_precharge", bus.coil, 1);
    bus.hwag_start = 1'b0;
    step();     chk("sync_loss_coil_off", bus.coil, 0);
    bus.hwag_start = 1'b1;
    step();
    tick(150);  chk("resync_first_tick_capture", bus.coil, 0);
    tick(190);
    tick(210);
    tick(3830);
    tick(50);
    tick(120);  chk("resync_rearmed", bus.coil, 1);

    // reset during charge clears the config
    rst = 1'b1;
    step();     chk("rst_mid_charge_coil", bus.coil, 0);
    rst = 1'b0;
    step();
    tick(50);
    for (int k = 1; k <= 70; k++) begin
      tick((50 + 64 * k) % M);
      chk("rst_config_cleared", bus.coil, 0);
    end

    // random traffic against the model
    cur = 0;
    for (int i = 0; i < 4000; i++) begin
      bus.hwag_start = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 29) == 0) begin
        r   = int'($urandom_range(0, 7));
        on  = int'($urandom_range(0, M - 1));
        off = (r == 0) ? on : int'($urandom_range(0, M - 1));
        if (r == 1) on = M + int'($urandom_range(0, 100));
        dw  = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 150));
        bus.cfg_on = on[AW-1:0]; bus.cfg_off = off[AW-1:0];
        bus.cfg_dwell_max = dw[DW-1:0]; bus.cfg_wr = 1'b1;
      end
      if ($urandom_range(0, 1) == 1) begin
        r   = int'($urandom_range(0, 19));
        inc = (r == 0) ? 0 : (r == 1) ? int'($urandom_range(1, M - 1)) : int'($urandom_range(1, 40));
        cur = (cur + inc) % M;
        bus.angle = cur[AW-1:0];
        bus.angle_tick = 1'b1;
      end
      step();
      bus.angle_tick = 1'b0;
      bus.cfg_wr = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/hwag_coil_channel.md
# hwag_coil_channel

Angle-driven ignition coil channel sitting directly downstream of the hardware angle generator (HWAG). It consumes the HWAG synchronisation flag and the 0..3839 main angle count (64 ticks per tooth, 60-tooth wheel). It drives one coil output: charge starts when the angle crosses a programmed on-angle and ends when it crosses a programmed off-angle. A double-buffered configuration and a dwell-time watchdog keep the coil safe across reconfiguration, angle jumps and loss of sync.

## Interface
- ANGLE_W, 16, angle bus width
- ANGLE_MOD, 3840, angle modulus; valid angles 0..ANGLE_MOD-1
- DWELL_W, 24, dwell watchdog counter width

- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- hwag_start  in  1  HWAG synchronised; angle valid only while high
- angle_tick  in  1  one-cycle strobe: `angle` updated this cycle
- angle  in  ANGLE_W  HWAG main angle count
- cfg_wr  in  1  one-cycle strobe: load shadow config
- cfg_on  in  ANGLE_W  charge-start angle
- cfg_off  in  ANGLE_W  charge-end (spark) angle
- cfg_dwell_max  in  DWELL_W  maximum charge time in clk cycles; 0 disables the watchdog
- coil  out  1  coil drive, high = charging
- cfg_err  out  1  one-cycle pulse: cfg_wr rejected
- dwell_fault  out  1  one-cycle pulse: watchdog forced coil off

## Operation
- Registers:
  - shadow {on, off, dwell_max} plus `shadow_pending` flag
  - active {on, off, dwell_max}
  - `prev_angle`
  - dwell counter (DWELL_W)
  - FSM
- Config write:
  - Rejected (cfg_err pulse, shadow unchanged) if cfg_on ≥ ANGLE_MOD, cfg_off ≥ ANGLE_MOD, or cfg_on == cfg_off.
  - Otherwise shadow is loaded and shadow_pending is set.
  - A later cfg_wr before transfer overwrites the shadow.
- Shadow→active transfer happens only when shadow_pending = 1, at these points:
  - entering WAIT_ON from SYNC;
  - leaving CHARGE for any reason;
  - a zero-length cycle in WAIT_ON.
  - Transfer clears shadow_pending.
- Crossing detection, evaluated on an angle_tick with a valid `prev_angle`:
  - d = (angle − prev_angle) mod ANGLE_MOD.
  - Target T is crossed iff 1 ≤ (T − prev_angle) mod ANGLE_MOD ≤ d and d < ANGLE_MOD/2.
  - d ≥ ANGLE_MOD/2 or d = 0 is a discontinuity: no crossing.
  - `prev_angle` ← `angle` on every tick.
  - Wrap 3839→0 is handled by the modulo arithmetic. Computation uses ANGLE_W+1 bits, no overflow.
- FSM:
  - IDLE: coil = 0. When hwag_start = 1, go to SYNC.
  - SYNC: on the first angle_tick, capture prev_angle, transfer shadow if pending, go to WAIT_ON.
  - WAIT_ON:
    - on-crossing alone → CHARGE, coil = 1, dwell counter cleared.
    - on- and off-crossing in the same tick → stay in WAIT_ON, coil stays 0, counts as a completed cycle (transfer).
    - off-crossing alone is ignored.
  - CHARGE: dwell counter increments every clk.
    - off-crossing → WAIT_ON, coil = 0.
    - dwell_max ≠ 0 and counter == dwell_max − 1 → WAIT_ON, coil = 0, dwell_fault pulse.
    - on-crossing ignored.
- hwag_start = 0 in any state: next cycle IDLE, coil = 0, prev_angle invalidated. Shadow and active are retained.
- Watchdog and off-crossing in the same cycle: off wins, no dwell_fault.

## Timing
- Reset values:
  - coil = 0, cfg_err = 0, dwell_fault = 0
  - FSM = IDLE, shadow_pending = 0
  - shadow/active on = off = 0, dwell_max = 0; this config crosses nothing until written
- coil changes exactly 1 clk after the angle_tick cycle that causes the crossing (registered output).
- Watchdog: with dwell_max = N, coil is high for exactly N clk cycles.
- cfg_err: 1 clk after cfg_wr. A transfer triggered in the same cycle as cfg_wr uses the pre-write shadow; the new write stays pending.
- hwag_start fall → coil low 1 clk later.
- rst mid-CHARGE → coil low 1 clk later, all state at reset values.
- angle_tick while IDLE is ignored.

## Test plan
- Sync and basic cycle:
  - Stimulus: write on = 100, off = 200, dwell_max = 0; raise hwag_start; ticks 0,1,2…
  - Required: coil rises 1 clk after tick with angle = 100, falls 1 clk after angle = 200.
- Wrap-around:
  - Stimulus: on = 3800, off = 40; ticks run 3790→3839→0→50.
  - Required: coil high from angle 3800 through 40, low after 40.
- Angle jump:
  - Stimulus: on = 500; angle jumps 480→520 in one tick.
  - Required: coil rises; jump 480→2500 (d ≥ 1920) produces no crossing.
- Watchdog:
  - Stimulus: on = 100, off = 300, dwell_max = 50; stop ticks after 150.
  - Required: coil high exactly 50 clk, dwell_fault one pulse, FSM back in WAIT_ON.
- Config safety:
  - Stimulus: cfg_wr with on = off = 700.
  - Required: cfg_err pulse, no change.
  - Stimulus: cfg_wr on = 1000, off = 1100 during CHARGE of 100/200.
  - Required: current cycle ends at 200; next cycle uses 1000/1100.
- Sync loss / reset:
  - Stimulus: drop hwag_start during CHARGE.
  - Required: coil = 0 next clk, IDLE; re-raise → SYNC; first tick only captures prev_angle.
  - Stimulus: rst during CHARGE.
  - Required: same, plus config cleared.
